// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared constants for the pipeline hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_REDIRECT = 2'd1;
  localparam state_t ST_MD_WAIT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hazard_cmp.sv
// ============================================================================
//  Module      : hazard_cmp
//  Description : Combinational load-use detector between the ID and EX stages.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use  = ex_mem_read && (ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline stall/flush controller (load-use, redirect, mul/div).
//                Optional performance counters under HAZARD_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              ex_muldiv_start,
  input  logic              muldiv_done,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush
);

  state_t r_state;
  state_t w_next;
  logic   w_load_use;

  hazard_cmp u_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (w_load_use)
  );

  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!reset) begin
      // Hold the whole front end idle and bubbled while in reset
      w_next      = ST_RUN;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_next      = ST_REDIRECT;
          end else if (ex_muldiv_start) begin
            // A same-cycle completion needs no wait state
            if (!muldiv_done) w_next = ST_MD_WAIT;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ST_REDIRECT: begin
          if_id_flush = 1'b1;
          w_next      = ST_RUN;
        end
        ST_MD_WAIT: begin
          if (muldiv_done) begin
            w_next = ST_RUN;
          end else begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
          end
        end
        default: w_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_id_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (directed + random).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read;
  logic       ex_redirect, ex_muldiv_start, muldiv_done;
  logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: pipeline is either busy on mul/div, squashing after a
  // redirect, or running freely.
  bit          m_md_busy;
  bit          m_squash;
  int unsigned m_stall;
  int unsigned m_flush;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_redirect     (ex_redirect),
    .ex_muldiv_start (ex_muldiv_start),
    .muldiv_done     (muldiv_done),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
`endif
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush)
  );

  // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}
  function automatic logic [4:0] model_out();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!reset)           return 5'b00011;
    if (m_squash)         return 5'b11110;
    if (m_md_busy)        return muldiv_done ? 5'b11100 : 5'b00000;
    if (ex_redirect)      return 5'b11111;
    if (ex_muldiv_start)  return 5'b11100;
    if (lu)               return 5'b00101;
    return 5'b11100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_md_busy = 0; m_squash = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
    ex_redirect = 0; ex_muldiv_start = 0; muldiv_done = 0;
  endtask

  // Inputs already driven; compare mid-cycle, then advance the model at the edge
  task automatic step(input string tag, input bit has_want = 0, input logic [4:0] want = 0);
    logic [4:0] exp, obs;
    #2;
    exp = model_out();
    obs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush};
    if (has_want) check({tag, "_dir"}, {27'd0, obs}, {27'd0, want});
    check(tag, {27'd0, obs}, {27'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, m_stall);
    check({tag, "_flush_cnt"}, flush_cnt, m_flush);
`endif
    @(posedge clk);
    if (reset) begin
      if (!exp[4]) m_stall++;
      if (exp[1])  m_flush++;
      if (m_squash)                                m_squash = 0;
      else if (m_md_busy)                          begin if (muldiv_done) m_md_busy = 0; end
      else if (ex_redirect)                        m_squash = 1;
      else if (ex_muldiv_start && !muldiv_done)    m_md_busy = 1;
    end
    #1;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    check("reset_outs", {27'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}, 32'h03);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    step("run_idle", 1, 5'b11100);

    // Load-use on rs1, then released next cycle
    ex_mem_read = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
    step("load_use", 1, 5'b00101);
    idle_inputs();
    step("load_use_after", 1, 5'b11100);

    // Same pattern on x0 must not stall
    ex_mem_read = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
    step("x0_no_stall", 1, 5'b11100);
    idle_inputs();

    // Redirect: two cycles of IF/ID flush, one of ID/EX flush
    ex_redirect = 1;
    step("redir_n", 1, 5'b11111);
    idle_inputs();
    ex_redirect = 1; ex_muldiv_start = 1;
    ex_mem_read = 1; ex_rd = 3; id_use_rs2 = 1; id_rs2 = 3;
    step("redir_n1_ignore", 1, 5'b11110);
    idle_inputs();
    step("redir_n2_run", 1, 5'b11100);

    // Mul/div: start N, done N+4
    ex_muldiv_start = 1;
    step("md_start", 1, 5'b11100);
    idle_inputs();
    ex_mem_read = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7;
    step("md_wait1_lu_masked", 1, 5'b00000);
    idle_inputs();
    ex_redirect = 1;
    step("md_wait2_redir_ign", 1, 5'b00000);
    idle_inputs();
    step("md_wait3", 1, 5'b00000);
    muldiv_done = 1;
    step("md_done", 1, 5'b11100);
    idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
    #2; check("md_stall_cnt_delta", stall_cnt, 32'd4); #0;
`endif
    muldiv_done = 1;
    step("done_in_run_ignored", 1, 5'b11100);
    idle_inputs();

    // Simultaneous redirect + start + load-use
    ex_redirect = 1; ex_muldiv_start = 1;
    ex_mem_read = 1; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9;
    step("simul_redir", 1, 5'b11111);
    idle_inputs();
    step("simul_squash", 1, 5'b11110);
    step("simul_run", 1, 5'b11100);

    // Reset asserted at N+2 of MD_WAIT
    ex_muldiv_start = 1;
    step("rst_md_start", 1, 5'b11100);
    idle_inputs();
    step("rst_md_wait1", 1, 5'b00000);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outs", {27'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}, 32'h03);
    model_reset();
`ifdef HAZARD_PERF_CNT_EN
    check("rst_stall_cleared", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    step("rst_release_run", 1, 5'b11100);
    step("rst_release_run2", 1, 5'b11100);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      ex_rd           = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_redirect     = ($urandom_range(0, 7) == 0);
      ex_muldiv_start = ($urandom_range(0, 5) == 0);
      muldiv_done     = m_md_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      if (!m_md_busy && !m_squash && ex_muldiv_start) muldiv_done = 0;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
